// File: rtl/placement_pkg.sv
// Shared types and helpers for the placement wirelength cost evaluator.
package placement_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EDGE = 3'd1,
        POSA = 3'd2,
        POSB = 3'd3,
        DIFF = 3'd4,
        ACC  = 3'd5,
        DONE = 3'd6
    } state_t;

    // Coordinate value marking a node that has not been placed (all ones at any width).
    localparam logic [63:0] UNPLACED = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // ceil(d / 2^h): shifted value plus one when any shifted-out bit was set.
    function automatic logic [63:0] hop_ceil(input logic [63:0] d, input int h);
        logic [63:0] rem_mask;
        rem_mask = (64'd1 << h) - 64'd1;
        return (d >> h) + 64'((d & rem_mask) != 64'd0);
    endfunction

endpackage

// File: rtl/placement_hop_term.sv
// One hop mode: per-edge hop count for distance (|dx|,|dy|) and saturating accumulate.
module placement_hop_term
    import placement_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ACC_W     = 32,
    parameter int HOP_SHIFT = 0
) (
    input  logic              en,
    input  logic [DATA_W:0]   abs_dx,
    input  logic [DATA_W:0]   abs_dy,
    input  logic [ACC_W-1:0]  acc_in,
    output logic [ACC_W-1:0]  acc_out,
    output logic              sat
);

    localparam int TW = DATA_W + 2;
    localparam int SW = ((ACC_W > TW) ? ACC_W : TW) + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    logic [TW-1:0] cx_s;
    logic [TW-1:0] cy_s;
    logic [TW-1:0] pair_s;
    logic [TW-1:0] term_s;
    logic [SW-1:0] sum_s;

    // Term is ceil(dx)+ceil(dy)-1, clamped at zero for coincident endpoints.
    always_comb begin
        cx_s   = TW'(hop_ceil(64'(abs_dx), HOP_SHIFT));
        cy_s   = TW'(hop_ceil(64'(abs_dy), HOP_SHIFT));
        pair_s = cx_s + cy_s;
        term_s = (pair_s == {TW{1'b0}}) ? {TW{1'b0}} : (pair_s - TW'(1));
        sum_s  = SW'(acc_in) + SW'(term_s);
        if (en && (sum_s > SW'(ACC_MAX))) begin
            acc_out = ACC_MAX;
            sat     = 1'b1;
        end else if (en) begin
            acc_out = sum_s[ACC_W-1:0];
            sat     = 1'b0;
        end else begin
            acc_out = acc_in;
            sat     = 1'b0;
        end
    end

endmodule

// File: rtl/placement_cost_eval.sv
// Walks the edge list, fetches both endpoint positions and accumulates hop-mode
// wirelength costs, tracking the longest Manhattan edge and error conditions.
module placement_cost_eval
    import placement_pkg::*;
#(
    parameter int N_NODES = 64,
    parameter int N_EDGES = 96,
    parameter int DATA_W  = 32,
    parameter int N_HOPS  = 3,
    parameter int ACC_W   = 32,
    localparam int AW     = addr_width(N_EDGES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      edge_re,
    output logic [AW-1:0]             edge_addr,
    input  logic [DATA_W-1:0]         edge_a,
    input  logic [DATA_W-1:0]         edge_b,
    output logic                      pos_re,
    output logic [DATA_W-1:0]         pos_addr,
    input  logic [DATA_W-1:0]         pos_x,
    input  logic [DATA_W-1:0]         pos_y,
    output logic [N_HOPS*ACC_W-1:0]   cost,
    output logic [DATA_W-1:0]         max_len,
    output logic                      err_unplaced,
    output logic                      err_overlap,
    output logic                      cost_sat
);

    localparam logic [DATA_W-1:0] UNPL = UNPLACED[DATA_W-1:0];

    if ((N_NODES < 1) || (N_EDGES < 1) || (DATA_W > 62)) begin : g_bad_cfg
        $error("placement_cost_eval: unsupported parameter set");
    end

    state_t                   state_r;
    logic [AW-1:0]            idx_r;
    logic [DATA_W-1:0]        b_id_r;
    logic [DATA_W-1:0]        xa_r;
    logic [DATA_W-1:0]        ya_r;
    logic signed [DATA_W:0]   dx_r;
    logic signed [DATA_W:0]   dy_r;
    logic                     skip_r;

    logic [DATA_W:0]          abs_dx_s;
    logic [DATA_W:0]          abs_dy_s;
    logic [DATA_W+1:0]        len_s;
    logic [N_HOPS*ACC_W-1:0]  acc_next_s;
    logic [N_HOPS-1:0]        sat_vec_s;
    logic                     b_unplaced_s;

    assign edge_addr = idx_r;

    // Magnitudes and Manhattan length of the current edge; position address mux.
    always_comb begin
        abs_dx_s     = dx_r[DATA_W] ? $unsigned(-dx_r) : $unsigned(dx_r);
        abs_dy_s     = dy_r[DATA_W] ? $unsigned(-dy_r) : $unsigned(dy_r);
        len_s        = {1'b0, abs_dx_s} + {1'b0, abs_dy_s};
        b_unplaced_s = (pos_x == UNPL) || (pos_y == UNPL);
        case (state_r)
            POSA:    pos_addr = edge_a;
            POSB:    pos_addr = b_id_r;
            default: pos_addr = {DATA_W{1'b0}};
        endcase
    end

    for (genvar h = 0; h < N_HOPS; h++) begin : g_hop
        placement_hop_term #(
            .DATA_W    (DATA_W),
            .ACC_W     (ACC_W),
            .HOP_SHIFT (h)
        ) u_term (
            .en      (!skip_r),
            .abs_dx  (abs_dx_s),
            .abs_dy  (abs_dy_s),
            .acc_in  (cost[h*ACC_W +: ACC_W]),
            .acc_out (acc_next_s[h*ACC_W +: ACC_W]),
            .sat     (sat_vec_s[h])
        );
    end

    // Run sequencer: five states per edge, registered strobes and results.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            idx_r        <= {AW{1'b0}};
            b_id_r       <= {DATA_W{1'b0}};
            xa_r         <= {DATA_W{1'b0}};
            ya_r         <= {DATA_W{1'b0}};
            dx_r         <= {(DATA_W+1){1'b0}};
            dy_r         <= {(DATA_W+1){1'b0}};
            skip_r       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            edge_re      <= 1'b0;
            pos_re       <= 1'b0;
            cost         <= {(N_HOPS*ACC_W){1'b0}};
            max_len      <= {DATA_W{1'b0}};
            err_unplaced <= 1'b0;
            err_overlap  <= 1'b0;
            cost_sat     <= 1'b0;
        end else begin
            edge_re <= 1'b0;
            pos_re  <= 1'b0;
            done    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        cost         <= {(N_HOPS*ACC_W){1'b0}};
                        max_len      <= {DATA_W{1'b0}};
                        err_unplaced <= 1'b0;
                        err_overlap  <= 1'b0;
                        cost_sat     <= 1'b0;
                        idx_r        <= {AW{1'b0}};
                        busy         <= 1'b1;
                        edge_re      <= 1'b1;
                        state_r      <= EDGE;
                    end
                end
                EDGE: begin
                    pos_re  <= 1'b1;
                    state_r <= POSA;
                end
                POSA: begin
                    b_id_r  <= edge_b;
                    pos_re  <= 1'b1;
                    state_r <= POSB;
                end
                POSB: begin
                    xa_r    <= pos_x;
                    ya_r    <= pos_y;
                    state_r <= DIFF;
                end
                DIFF: begin
                    dx_r    <= $signed({xa_r[DATA_W-1], xa_r}) - $signed({pos_x[DATA_W-1], pos_x});
                    dy_r    <= $signed({ya_r[DATA_W-1], ya_r}) - $signed({pos_y[DATA_W-1], pos_y});
                    skip_r  <= (xa_r == UNPL) || (ya_r == UNPL) || b_unplaced_s;
                    state_r <= ACC;
                end
                ACC: begin
                    if (skip_r) begin
                        err_unplaced <= 1'b1;
                    end else begin
                        cost     <= acc_next_s;
                        cost_sat <= cost_sat | (|sat_vec_s);
                        if (len_s == {(DATA_W+2){1'b0}}) begin
                            err_overlap <= 1'b1;
                        end
                        // Lengths beyond the output width clamp to all ones.
                        if (len_s > {2'b00, max_len}) begin
                            max_len <= (len_s > {2'b00, {DATA_W{1'b1}}}) ?
                                       {DATA_W{1'b1}} : len_s[DATA_W-1:0];
                        end
                    end
                    if (idx_r == AW'(N_EDGES - 1)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        idx_r   <= idx_r + AW'(1);
                        edge_re <= 1'b1;
                        state_r <= EDGE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_placement_cost_eval.sv
// Scoreboard bench: driver pushes expected run results, monitor pops them on done.
module tb_placement_cost_eval;

    localparam int N_NODES = 16;
    localparam int N_EDGES = 4;
    localparam int DATA_W  = 16;
    localparam int N_HOPS  = 3;
    localparam int ACC_W   = 8;
    localparam int AW      = 2;
    localparam int CW      = N_HOPS * ACC_W;
    localparam longint ACC_MAX = (64'sd1 <<< ACC_W) - 64'sd1;
    localparam logic [DATA_W-1:0] UNPL = 16'hFFFF;

    logic clk = 1'b0;
    logic reset, start;
    logic busy, done, edge_re, pos_re;
    logic [AW-1:0] edge_addr;
    logic [DATA_W-1:0] edge_a, edge_b, pos_addr, pos_x, pos_y, max_len;
    logic [CW-1:0] cost;
    logic err_unplaced, err_overlap, cost_sat;

    always #5 clk = ~clk;

    placement_cost_eval #(
        .N_NODES(N_NODES), .N_EDGES(N_EDGES), .DATA_W(DATA_W),
        .N_HOPS(N_HOPS), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .edge_re(edge_re), .edge_addr(edge_addr), .edge_a(edge_a), .edge_b(edge_b),
        .pos_re(pos_re), .pos_addr(pos_addr), .pos_x(pos_x), .pos_y(pos_y),
        .cost(cost), .max_len(max_len), .err_unplaced(err_unplaced),
        .err_overlap(err_overlap), .cost_sat(cost_sat)
    );

    logic [DATA_W-1:0] rom_a [N_EDGES];
    logic [DATA_W-1:0] rom_b [N_EDGES];
    logic [DATA_W-1:0] px [N_NODES];
    logic [DATA_W-1:0] py [N_NODES];

    // Synchronous edge ROM and position RAM: data one cycle after the read enable.
    always @(posedge clk) begin
        if (edge_re) begin
            edge_a <= rom_a[edge_addr];
            edge_b <= rom_b[edge_addr];
        end
        if (pos_re) begin
            pos_x <= px[pos_addr[3:0]];
            pos_y <= py[pos_addr[3:0]];
        end
    end

    typedef struct {
        logic [CW-1:0]     cost;
        logic [DATA_W-1:0] max_len;
        logic              unp;
        logic              ov;
        logic              sat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: sums ceil-divided hop counts per edge using plain integer arithmetic.
    function automatic exp_t model();
        exp_t e;
        longint acc [N_HOPS];
        longint ml;
        e.unp = 1'b0; e.ov = 1'b0; e.sat = 1'b0; ml = 0;
        for (int h = 0; h < N_HOPS; h++) acc[h] = 0;
        for (int i = 0; i < N_EDGES; i++) begin
            int a, b;
            longint ax, ay, bx, by, ddx, ddy;
            a = int'(rom_a[i]); b = int'(rom_b[i]);
            if (px[a] == UNPL || py[a] == UNPL || px[b] == UNPL || py[b] == UNPL) begin
                e.unp = 1'b1;
                continue;
            end
            ax = longint'($signed(px[a])); ay = longint'($signed(py[a]));
            bx = longint'($signed(px[b])); by = longint'($signed(py[b]));
            ddx = (ax > bx) ? ax - bx : bx - ax;
            ddy = (ay > by) ? ay - by : by - ay;
            if (ddx + ddy > ml) ml = ddx + ddy;
            if (ddx == 0 && ddy == 0) e.ov = 1'b1;
            for (int h = 0; h < N_HOPS; h++) begin
                longint step, t;
                step = longint'(1) << h;
                t = (ddx + step - 1) / step + (ddy + step - 1) / step - 1;
                if (t < 0) t = 0;
                acc[h] += t;
                if (acc[h] > ACC_MAX) begin
                    acc[h] = ACC_MAX;
                    e.sat = 1'b1;
                end
            end
        end
        for (int h = 0; h < N_HOPS; h++) e.cost[h*ACC_W +: ACC_W] = ACC_W'(acc[h]);
        e.max_len = DATA_W'(ml);
        return e;
    endfunction

    function automatic exp_t mk(input int c0, input int c1, input int c2, input int ml,
                                input bit u, input bit o, input bit s);
        exp_t e;
        e.cost = {ACC_W'(c2), ACC_W'(c1), ACC_W'(c0)};
        e.max_len = DATA_W'(ml);
        e.unp = u; e.ov = o; e.sat = s;
        return e;
    endfunction

    // Monitor: every done pulse is matched against the oldest pushed expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset && busy) check("re_exclusive", longint'(edge_re & pos_re), 0);
        if (reset && done) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1, expected no pending run");
            end else begin
                e = sb.pop_front();
                for (int h = 0; h < N_HOPS; h++)
                    check($sformatf("cost_mode%0d", h), longint'(cost[h*ACC_W +: ACC_W]),
                          longint'(e.cost[h*ACC_W +: ACC_W]));
                check("max_len", longint'(max_len), longint'(e.max_len));
                check("err_unplaced", longint'(err_unplaced), longint'(e.unp));
                check("err_overlap", longint'(err_overlap), longint'(e.ov));
                check("cost_sat", longint'(cost_sat), longint'(e.sat));
                check("busy_at_done", longint'(busy), 0);
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_edge_re"}, longint'(edge_re), 0);
        check({tag, "_pos_re"}, longint'(pos_re), 0);
        check({tag, "_edge_addr"}, longint'(edge_addr), 0);
        check({tag, "_pos_addr"}, longint'(pos_addr), 0);
        check({tag, "_cost"}, longint'(cost), 0);
        check({tag, "_max_len"}, longint'(max_len), 0);
        check({tag, "_flags"}, longint'({err_unplaced, err_overlap, cost_sat}), 0);
    endtask

    // Driver: pulse start at a negedge, optionally re-pulse while busy, time done.
    task automatic run(input exp_t e, input bit dbl);
        int cyc;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 300) begin
            start = (dbl && cyc == 3) ? 1'b1 : 1'b0;
            if (cyc == 2) check("busy_mid_run", longint'(busy), 1);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_latency", longint'(cyc), longint'(5 * N_EDGES + 1));
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic all_edges(input int a, input int b);
        for (int i = 0; i < N_EDGES; i++) begin
            rom_a[i] = DATA_W'(a);
            rom_b[i] = DATA_W'(b);
        end
    endtask

    task automatic set_node(input int n, input int x, input int y);
        px[n] = DATA_W'(x);
        py[n] = DATA_W'(y);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        for (int n = 0; n < N_NODES; n++) set_node(n, n, 2 * n);
        all_edges(0, 1);
        repeat (3) @(negedge clk);
        check_reset_state("reset");

        // (0,0)-(3,4): per edge {6,3,1}, length 7; start on first cycle out of reset.
        set_node(0, 0, 0);
        set_node(1, 3, 4);
        reset = 1'b1;
        run(mk(24, 12, 4, 7, 0, 0, 0), 1'b0);

        // Adjacent nodes contribute nothing in any mode.
        set_node(2, 2, 2);
        set_node(3, 2, 3);
        all_edges(2, 3);
        run(mk(0, 0, 0, 1, 0, 0, 0), 1'b0);

        // One edge touches an unplaced node (y = -1); the rest are (0,0)-(3,4).
        set_node(4, 7, -1);
        all_edges(0, 1);
        rom_b[0] = DATA_W'(4);
        run(mk(18, 9, 3, 7, 1, 0, 0), 1'b0);

        // Coincident endpoints.
        set_node(5, 5, 5);
        set_node(6, 5, 5);
        all_edges(5, 6);
        run(mk(0, 0, 0, 0, 0, 1, 0), 1'b0);

        // (0,0)-(30,40): mode0 saturates at 255, mode1 34*4, mode2 17*4.
        set_node(7, 30, 40);
        all_edges(0, 7);
        run(mk(255, 136, 68, 70, 0, 0, 1), 1'b0);

        // Abort a run in its third cycle, then re-pulse start while busy.
        all_edges(0, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("midrun_reset");
        reset = 1'b1;
        run(mk(24, 12, 4, 7, 0, 0, 0), 1'b1);

        // Randomised runs against the reference model.
        for (int r = 0; r < 12; r++) begin
            bit big;
            big = (r % 3 == 0);
            for (int n = 0; n < N_NODES; n++) begin
                int x, y;
                x = big ? int'($urandom_range(24000)) - 12000 : int'($urandom_range(12)) - 6;
                y = big ? int'($urandom_range(24000)) - 12000 : int'($urandom_range(12)) - 6;
                set_node(n, x, y);
                if ($urandom_range(19) == 0) px[n] = UNPL;
            end
            for (int i = 0; i < N_EDGES; i++) begin
                rom_a[i] = DATA_W'($urandom_range(N_NODES - 1));
                rom_b[i] = DATA_W'($urandom_range(N_NODES - 1));
            end
            run(model(), (r % 4 == 1));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", longint'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/placement_cost_eval.md
PLACEMENT_COST_EVAL -- requirements
Module: placement_cost_eval

Interface
REQ-001 SHALL have parameter N_NODES, default 64: number of placed nodes; node IDs lie in 0..N_NODES-1.
REQ-002 SHALL have parameter N_EDGES, default 96: number of edges evaluated per run (>=1).
REQ-003 SHALL have parameter DATA_W, default 32: width of memory data words; coordinates are signed DATA_W.
REQ-004 SHALL have parameter N_HOPS, default 3: number of hop modes; mode h uses hop length 2^h, h=0..N_HOPS-1.
REQ-005 SHALL have parameter ACC_W, default 32: width of each cost accumulator.
REQ-006 SHALL use one clock; reset is synchronous and active-low.
REQ-007 Ports SHALL be, in this order:
 clk  in  1  clock;
 reset  in  1  synchronous active-low reset;
 start  in  1  one-cycle run request;
 busy  out  1  run in progress;
 done  out  1  one-cycle completion pulse;
 edge_re  out  1  edge ROM read enable;
 edge_addr  out  clog2(N_EDGES)  edge index;
 edge_a, edge_b  in  DATA_W  endpoint node IDs, valid one cycle after edge_re;
 pos_re  out  1  position RAM read enable;
 pos_addr  out  DATA_W  node ID;
 pos_x, pos_y  in  DATA_W  signed coordinates, valid one cycle after pos_re;
 cost  out  N_HOPS*ACC_W  flattened accumulators, mode h at bits [h*ACC_W +: ACC_W];
 max_len  out  DATA_W  largest |dx|+|dy| seen;
 err_unplaced, err_overlap, cost_sat  out  1  sticky flags.

Function
REQ-008 States SHALL be IDLE, EDGE, POSA, POSB, DIFF, ACC, DONE.
REQ-009 IDLE: start=1 SHALL clear cost, max_len, all flags and edge index i, set busy=1, and go to EDGE.
REQ-010 start while busy=1 SHALL be ignored.
REQ-011 EDGE SHALL assert edge_re with edge_addr=i.
REQ-012 POSA SHALL latch edge_a/edge_b and assert pos_re with pos_addr=edge_a.
REQ-013 POSB SHALL latch A coordinates and assert pos_re with pos_addr=b.
REQ-014 DIFF SHALL latch B coordinates and compute dx=xa-xb and dy=ya-yb in DATA_W+1 signed.
REQ-015 ACC SHALL form |dx| and |dy|, update all accumulators in the same cycle, then increment i; it SHALL go to DONE when i=N_EDGES-1, else to EDGE.
REQ-016 Each edge SHALL take exactly 5 cycles; done SHALL pulse 5*N_EDGES+1 cycles after the cycle start is accepted.
REQ-017 The per-edge term for mode h SHALL be ceil(|dx|/2^h)+ceil(|dy|/2^h)-1, where ceil(d/2^h) = (d>>h) + (d[h-1:0]!=0) and the h=0 remainder is 0.
REQ-018 Any coordinate of A or B equal to all-ones (unplaced) SHALL set err_unplaced, skip all accumulation for that edge, and leave max_len unchanged.
REQ-019 dx=dy=0 SHALL set err_overlap and add 0 to every mode; the term SHALL never be negative.
REQ-020 Accumulators SHALL saturate at 2^ACC_W-1; any saturation SHALL set cost_sat.
REQ-021 max_len SHALL update when |dx|+|dy| of a non-skipped edge exceeds the current value.
REQ-022 DONE SHALL assert done=1 and busy=0 for one cycle, then go to IDLE; cost, max_len and flags SHALL hold until the next accepted start.
REQ-023 edge_re and pos_re SHALL be single-cycle pulses; they SHALL never be asserted together.

Reset
REQ-024 reset=0 at a clock edge SHALL, at any state including mid-run, force IDLE and zero busy, done, edge_re, pos_re, edge_addr, pos_addr, cost, max_len and all flags.
REQ-025 The first start SHALL be accepted on the first cycle after reset returns to 1.

Structure
REQ-026 Shared package placement_pkg SHALL hold the state enum, the UNPLACED constant (all-ones), and the hop-ceil width helper.
REQ-027 Per-mode term and saturating add SHALL live in sub-module placement_hop_term (parameter HOP_SHIFT), instantiated N_HOPS times in a generate loop.

Verification (N_HOPS=3, ACC_W=32)
REQ-028 N_EDGES=1; node0=(0,0), node1=(3,4) -> cost={6,3,1} for modes 0/1/2, max_len=7, done at cycle 6, no flags set.
REQ-029 Adjacent nodes (2,2),(2,3) -> all costs 0, max_len=1, no flags set.
REQ-030 Edge with node y=-1 plus edge (0,0)-(3,4) -> err_unplaced=1, cost={6,3,1}.
REQ-031 Both endpoints at (5,5) -> err_overlap=1, costs 0, max_len=0.
REQ-032 ACC_W=4, three edges of (0,0)-(3,4) -> cost mode0=15, cost_sat=1, mode1=9, mode2=3.
REQ-033 reset=0 in the third cycle of a run, start re-pulsed while busy on a following run -> outputs zero after reset; the second start is ignored and done arrives at 5*N_EDGES+1 from the first accepted start.
